// File: rtl/anti_theft_sequencer.sv
// Car anti-theft main sequencer: selects the active timer interval, runs a 1 Hz
// countdown loaded from the parameter bank, and drives siren and status LED.
module anti_theft_sequencer #(
  parameter int unsigned TIMER_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               one_hz_enable,
  input  logic               ignition,
  input  logic               driver_door,
  input  logic               passenger_door,
  input  logic               reprogram,
  input  logic [TIMER_W-1:0] timer_value,
  output logic [1:0]         timer_interval,
  output logic [TIMER_W-1:0] time_left,
  output logic               siren,
  output logic               status_indicator,
  output logic [2:0]         fsm_state
);

  localparam logic [2:0] ST_ARMED      = 3'b000;
  localparam logic [2:0] ST_TRIGGERED  = 3'b001;
  localparam logic [2:0] ST_ALARM      = 3'b010;
  localparam logic [2:0] ST_DISARMED   = 3'b011;
  localparam logic [2:0] ST_WAIT_OPEN  = 3'b100;
  localparam logic [2:0] ST_WAIT_CLOSE = 3'b101;
  localparam logic [2:0] ST_ARM_WAIT   = 3'b110;

  localparam logic [1:0] IV_ARM       = 2'b00;
  localparam logic [1:0] IV_DRIVER    = 2'b01;
  localparam logic [1:0] IV_PASSENGER = 2'b10;
  localparam logic [1:0] IV_ALARM_ON  = 2'b11;

  logic [2:0] state, state_next;
  logic [1:0] interval_next;
  logic       load_pending, load_next;
  logic       siren_next, led_next;
  logic       clear_count;
  logic       expired;
  logic       any_door;

  assign expired  = (time_left == '0) && !load_pending;
  assign any_door = driver_door || passenger_door;

  // Next-state, interval select and registered-output values
  always_comb begin
    state_next    = state;
    interval_next = timer_interval;
    load_next     = 1'b0;
    clear_count   = 1'b0;
    siren_next    = 1'b0;
    led_next      = 1'b0;
    if (reprogram) begin
      state_next    = ST_ARMED;
      interval_next = IV_ARM;
      clear_count   = 1'b1;
    end else begin
      case (state)
        ST_ARMED: begin
          if (driver_door) begin
            state_next    = ST_TRIGGERED;
            interval_next = IV_DRIVER;
            load_next     = 1'b1;
          end else if (passenger_door) begin
            state_next    = ST_TRIGGERED;
            interval_next = IV_PASSENGER;
            load_next     = 1'b1;
          end
        end
        ST_TRIGGERED: begin
          if (ignition) begin
            state_next = ST_DISARMED;
          end else if (expired) begin
            state_next    = ST_ALARM;
            interval_next = IV_ALARM_ON;
            load_next     = 1'b1;
          end
        end
        ST_ALARM: begin
          // An open door keeps the alarm count parked at its full length
          if (ignition) begin
            state_next = ST_DISARMED;
          end else if (any_door) begin
            load_next = 1'b1;
          end else if (expired) begin
            state_next    = ST_ARMED;
            interval_next = IV_ARM;
          end
        end
        ST_DISARMED: begin
          if (!ignition) state_next = ST_WAIT_OPEN;
        end
        ST_WAIT_OPEN: begin
          if (ignition)         state_next = ST_DISARMED;
          else if (driver_door) state_next = ST_WAIT_CLOSE;
        end
        ST_WAIT_CLOSE: begin
          if (ignition) begin
            state_next = ST_DISARMED;
          end else if (!any_door) begin
            state_next    = ST_ARM_WAIT;
            interval_next = IV_ARM;
            load_next     = 1'b1;
          end
        end
        ST_ARM_WAIT: begin
          if (ignition)      state_next = ST_DISARMED;
          else if (any_door) state_next = ST_WAIT_CLOSE;
          else if (expired)  state_next = ST_ARMED;
        end
        default: begin
          state_next    = ST_ARMED;
          interval_next = IV_ARM;
        end
      endcase
    end

    siren_next = (state_next == ST_ALARM);
    case (state_next)
      ST_TRIGGERED, ST_ALARM: led_next = 1'b1;
      // Blink only while staying armed; entering ARMED restarts the phase at 0
      ST_ARMED: led_next = (state == ST_ARMED && !reprogram) ?
                           (status_indicator ^ one_hz_enable) : 1'b0;
      default:  led_next = 1'b0;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_ARMED;
      timer_interval   <= IV_ARM;
      siren            <= 1'b0;
      status_indicator <= 1'b0;
      load_pending     <= 1'b0;
    end else begin
      state            <= state_next;
      timer_interval   <= interval_next;
      siren            <= siren_next;
      status_indicator <= led_next;
      load_pending     <= load_next;
    end
  end

  // Countdown: a pending load wins over a tick; saturates at zero
  always_ff @(posedge clk) begin
    if (reset || clear_count) begin
      time_left <= '0;
    end else if (load_pending) begin
      time_left <= timer_value;
    end else if (one_hz_enable && time_left != '0) begin
      time_left <= time_left - TIMER_W'(1);
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_anti_theft_sequencer.sv
// Scoreboard bench for anti_theft_sequencer: stimulus queues expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_anti_theft_sequencer;

  logic       clk = 1'b0;
  logic       reset, one_hz_enable, ignition, driver_door, passenger_door, reprogram;
  logic [3:0] timer_value;
  logic [1:0] timer_interval;
  logic [3:0] time_left;
  logic       siren, status_indicator;
  logic [2:0] fsm_state;

  logic [3:0] len [4];
  assign timer_value = len[timer_interval];

  anti_theft_sequencer #(.TIMER_W(4)) dut (
    .clk(clk), .reset(reset), .one_hz_enable(one_hz_enable), .ignition(ignition),
    .driver_door(driver_door), .passenger_door(passenger_door), .reprogram(reprogram),
    .timer_value(timer_value), .timer_interval(timer_interval), .time_left(time_left),
    .siren(siren), .status_indicator(status_indicator), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  localparam int K_STATE = 0, K_IV = 1, K_TL = 2, K_SIREN = 3, K_LED = 4;

  typedef struct { string name; int kind; int val; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  exp_t m_e;
  int   m_act;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      m_e = sb.pop_front();
      case (m_e.kind)
        K_STATE: m_act = int'(fsm_state);
        K_IV:    m_act = int'(timer_interval);
        K_TL:    m_act = int'(time_left);
        K_SIREN: m_act = int'(siren);
        default: m_act = int'(status_indicator);
      endcase
      checks++;
      if (m_act != m_e.val) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", m_e.name, m_act, m_e.val);
      end
    end
  end

  task automatic ex(input string name, input int kind, input int val);
    exp_t e;
    e.name = name; e.kind = kind; e.val = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    one_hz_enable = 1'b1;
    tick();
    one_hz_enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    len[0] = 4'd6; len[1] = 4'd8; len[2] = 4'd15; len[3] = 4'd10;
    reset = 1'b1; one_hz_enable = 1'b0; ignition = 1'b0;
    driver_door = 1'b0; passenger_door = 1'b0; reprogram = 1'b0;
    tick(); tick();
    reset = 1'b0;
    ex("rst_state", K_STATE, 0); ex("rst_iv", K_IV, 0); ex("rst_tl", K_TL, 0);
    ex("rst_siren", K_SIREN, 0); ex("rst_led", K_LED, 0);

    // Armed blink
    pulse(); ex("blink1", K_LED, 1);
    pulse(); ex("blink2", K_LED, 0);
    pulse(); ex("blink3", K_LED, 1); ex("blink_state", K_STATE, 0); ex("blink_siren", K_SIREN, 0);

    // Driver trigger, 8 s, into alarm
    driver_door = 1'b1; tick(); driver_door = 1'b0;
    ex("trig_state", K_STATE, 1); ex("trig_iv", K_IV, 1); ex("trig_led", K_LED, 1);
    tick(); ex("trig_load", K_TL, 8);
    for (int i = 0; i < 7; i++) pulse();
    ex("trig_tl1", K_TL, 1); ex("trig_hold", K_STATE, 1);
    pulse(); ex("trig_tl0", K_TL, 0); ex("trig_still", K_STATE, 1);
    tick(); ex("alarm_state", K_STATE, 2); ex("alarm_siren", K_SIREN, 1); ex("alarm_iv", K_IV, 3);
    tick(); ex("alarm_load", K_TL, 10);

    // Door held open freezes alarm countdown
    driver_door = 1'b1; tick();
    for (int i = 0; i < 20; i++) pulse();
    ex("alarm_frozen", K_TL, 10); ex("alarm_frozen_st", K_STATE, 2);
    driver_door = 1'b0; tick(); ex("alarm_reload", K_TL, 10);
    for (int i = 0; i < 9; i++) pulse();
    ex("alarm_tl1", K_TL, 1);
    pulse(); ex("alarm_tl0", K_TL, 0); ex("alarm_tl0_st", K_STATE, 2);
    tick(); ex("rearm_state", K_STATE, 0); ex("rearm_siren", K_SIREN, 0);
    ex("rearm_iv", K_IV, 0); ex("rearm_led", K_LED, 0);

    // Passenger trigger, disarm by ignition
    passenger_door = 1'b1; tick(); passenger_door = 1'b0;
    ex("ptrig_state", K_STATE, 1); ex("ptrig_iv", K_IV, 2);
    tick(); ex("ptrig_load", K_TL, 15);
    for (int i = 0; i < 5; i++) pulse();
    ex("ptrig_tl", K_TL, 10);
    ignition = 1'b1; tick();
    ex("disarm_state", K_STATE, 3); ex("disarm_siren", K_SIREN, 0); ex("disarm_led", K_LED, 0);

    // Exit sequence and arm-wait restart
    ignition = 1'b0; tick(); ex("wait_open", K_STATE, 4);
    driver_door = 1'b1; tick(); ex("wait_close", K_STATE, 5);
    driver_door = 1'b0; tick(); ex("arm_wait", K_STATE, 6); ex("arm_wait_iv", K_IV, 0);
    tick(); ex("arm_wait_load", K_TL, 6);
    for (int i = 0; i < 3; i++) pulse();
    ex("arm_wait_tl3", K_TL, 3);
    driver_door = 1'b1; tick(); ex("reopen", K_STATE, 5);
    driver_door = 1'b0; tick(); ex("reclose", K_STATE, 6);
    tick(); ex("arm_wait_reload", K_TL, 6);
    for (int i = 0; i < 5; i++) pulse();
    ex("arm_wait_tl1", K_TL, 1);
    pulse(); ex("arm_wait_tl0", K_STATE, 6);
    tick(); ex("armed_again", K_STATE, 0); ex("armed_again_led", K_LED, 0);

    // Ignition ignored while armed
    ignition = 1'b1; tick(); ex("armed_ign", K_STATE, 0); ignition = 1'b0;

    // Zero-length driver interval, then reprogram mid-alarm
    len[1] = 4'd0;
    driver_door = 1'b1; tick(); driver_door = 1'b0; ex("z_trig", K_STATE, 1);
    tick(); ex("z_load", K_TL, 0); ex("z_not_yet", K_STATE, 1);
    tick(); ex("z_alarm", K_STATE, 2);
    tick(); ex("z_alarm_load", K_TL, 10);
    reprogram = 1'b1; driver_door = 1'b1; tick();
    ex("reprog_state", K_STATE, 0); ex("reprog_siren", K_SIREN, 0);
    ex("reprog_tl", K_TL, 0); ex("reprog_iv", K_IV, 0);
    tick(); ex("reprog_hold", K_STATE, 0);
    reprogram = 1'b0; driver_door = 1'b0; tick();

    // Reset mid-alarm countdown
    driver_door = 1'b1; tick(); driver_door = 1'b0;
    tick(); tick(); ex("r_alarm", K_STATE, 2);
    tick(); pulse(); ex("r_tl9", K_TL, 9);
    reset = 1'b1; tick(); reset = 1'b0;
    ex("r_state", K_STATE, 0); ex("r_tl", K_TL, 0); ex("r_siren", K_SIREN, 0);
    ex("r_iv", K_IV, 0); ex("r_led", K_LED, 0);
    tick(); tick(); ex("r_no_residual", K_STATE, 0); ex("r_no_residual_tl", K_TL, 0);

    tick();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
